mips_mem_loader: RTL and testbench

//  Boot-time loader upstream of PipelinedMIPS: takes a framed byte stream (valid/ready),

---
 rtl/mips_mem_loader.sv | 190 +++++++++++++++++++
 tb/tb_mips_mem_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_loader.sv
// -----------------------------------------------------------------------------
// mips_mem_loader
//   Boot-time loader for PipelinedMIPS. Parses a framed byte stream, assembles
//   big-endian 32-bit words and writes them into InstrMem or DataMem. The core
//   is held in reset (core_rstb=0) until an END header has been accepted.
//
//   Frame : HDR, CNT_HI, CNT_LO, ADDR_HI, ADDR_LO, CNT x {B3,B2,B1,B0} [, CSUM]
//   END   : the single byte HDR_END
//
//   Optional feature macro: MIPS_LOADER_CSUM_EN
//     defined   - every section frame ends with an XOR checksum of its data
//                 bytes; a mismatch is a sticky error.
//     undefined - no checksum byte; DATA returns to IDLE after the last write.
//
// Ports
//   clk        in   1       system clock, rising edge
//   rst        in   1       asynchronous reset, active-high
//   rx_valid   in   1       rx_data holds a byte
//   rx_ready   out  1       byte accepted when rx_valid & rx_ready
//   rx_data    in   8       stream byte
//   imem_we    out  1       one-cycle write strobe to InstrMem
//   dmem_we    out  1       one-cycle write strobe to DataMem
//   mem_addr   out  ADDR_W  word address for the active strobe
//   mem_wdata  out  32      word for the active strobe
//   core_rstb  out  1       active-low core reset, released once DONE
//   done       out  1       image fully loaded
//   err        out  1       framing / checksum error (sticky)
// -----------------------------------------------------------------------------
module mips_mem_loader #(
   parameter int          ADDR_W   = 10,
   parameter logic [7:0]  HDR_IMEM = 8'hA5,
   parameter logic [7:0]  HDR_DMEM = 8'h5A,
   parameter logic [7:0]  HDR_END  = 8'hFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic [7:0]        rx_data,
   output logic              imem_we,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_rstb,
   output logic              done,
   output logic              err
);

   typedef enum logic [3:0] {
      S_IDLE, S_CNT_HI, S_CNT_LO, S_ADR_HI, S_ADR_LO, S_DATA, S_DONE, S_ERROR
`ifdef MIPS_LOADER_CSUM_EN
      , S_CSUM
`endif
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   state_t            w_after_data;   // where a section goes once its data is done

   logic [15:0]       r_cnt;          // words still to be written
   logic [ADDR_W-1:0] r_addr;         // address of the word being assembled
   logic [7:0]        r_addr_hi;
   logic [23:0]       r_shift;        // first three bytes of the current word
   logic [1:0]        r_byte_idx;
   logic              r_sel_imem;     // 1: section targets InstrMem
`ifdef MIPS_LOADER_CSUM_EN
   logic [7:0]        r_csum;
`endif

   logic              w_xfer;
   logic              w_word_done;
   logic              w_imem_we_d;
   logic              w_dmem_we_d;
   logic              w_ready_d;
   logic              w_done_d;
   logic              w_err_d;

   assign w_xfer = rx_valid & rx_ready;

`ifdef MIPS_LOADER_CSUM_EN
   assign w_after_data = S_CSUM;
`else
   assign w_after_data = S_IDLE;
`endif

   // State register
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state logic
   // NOTE: the default assignment at the top keeps this block free of latches.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_xfer) begin
            if (rx_data == HDR_IMEM || rx_data == HDR_DMEM) w_next_state = S_CNT_HI;
            else if (rx_data == HDR_END)                    w_next_state = S_DONE;
            else                                            w_next_state = S_ERROR;
         end
         S_CNT_HI: if (w_xfer) w_next_state = S_CNT_LO;
         S_CNT_LO: if (w_xfer) w_next_state = S_ADR_HI;
         S_ADR_HI: if (w_xfer) w_next_state = S_ADR_LO;
         S_ADR_LO: if (w_xfer) w_next_state = (r_cnt == 16'd0) ? w_after_data : S_DATA;
         S_DATA:   if (w_xfer && r_byte_idx == 2'd3 && r_cnt == 16'd1)
                      w_next_state = w_after_data;
`ifdef MIPS_LOADER_CSUM_EN
         S_CSUM:   if (w_xfer) w_next_state = (rx_data == r_csum) ? S_IDLE : S_ERROR;
`endif
         default:  w_next_state = r_state;   // DONE and ERROR are terminal
      endcase
   end

   // Output decode: next values of the registered outputs
   always_comb begin
      w_word_done = (r_state == S_DATA) && w_xfer && (r_byte_idx == 2'd3);
      w_imem_we_d = w_word_done &  r_sel_imem;
      w_dmem_we_d = w_word_done & ~r_sel_imem;
      w_done_d    = (w_next_state == S_DONE);
      w_err_d     = (w_next_state == S_ERROR);
      w_ready_d   = ~w_done_d & ~w_err_d;
   end

   // Output registers and datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_ready   <= 1'b0;
         imem_we    <= 1'b0;
         dmem_we    <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         core_rstb  <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         r_cnt      <= '0;
         r_addr     <= '0;
         r_addr_hi  <= '0;
         r_shift    <= '0;
         r_byte_idx <= '0;
         r_sel_imem <= 1'b0;
`ifdef MIPS_LOADER_CSUM_EN
         r_csum     <= '0;
`endif
      end else begin
         rx_ready  <= w_ready_d;
         imem_we   <= w_imem_we_d;
         dmem_we   <= w_dmem_we_d;
         done      <= w_done_d;
         core_rstb <= w_done_d;
         err       <= w_err_d;

         // Completed word: present it with its address, then step the section
         if (w_word_done) begin
            mem_addr  <= r_addr;
            mem_wdata <= {r_shift, rx_data};
            r_addr    <= r_addr + ADDR_W'(1);   // wraps modulo 2^ADDR_W
            r_cnt     <= r_cnt - 16'd1;
         end

         if (w_xfer) begin
            case (r_state)
               S_IDLE: begin
                  r_sel_imem <= (rx_data == HDR_IMEM);
                  r_byte_idx <= 2'd0;
`ifdef MIPS_LOADER_CSUM_EN
                  r_csum     <= 8'd0;
`endif
               end
               S_CNT_HI: r_cnt[15:8] <= rx_data;
               S_CNT_LO: r_cnt[7:0]  <= rx_data;
               S_ADR_HI: r_addr_hi   <= rx_data;
               // The 16-bit address field is truncated to the memory width
               S_ADR_LO: r_addr      <= ADDR_W'({r_addr_hi, rx_data});
               S_DATA: begin
                  r_shift    <= {r_shift[15:0], rx_data};
                  r_byte_idx <= r_byte_idx + 2'd1;
`ifdef MIPS_LOADER_CSUM_EN
                  r_csum     <= r_csum ^ rx_data;
`endif
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mips_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_mips_mem_loader
//   Self-checking bench for mips_mem_loader. A byte-position model of the
//   frame format predicts, cycle by cycle, the strobes, address, data and
//   status outputs; directed frames add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_mips_mem_loader;

   localparam int ADDR_W = 10;
`ifdef MIPS_LOADER_CSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_ready;
   logic              imem_we;
   logic              dmem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              core_rstb;
   logic              done;
   logic              err;

   mips_mem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .imem_we   (imem_we),
      .dmem_we   (dmem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .core_rstb (core_rstb),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model -------------------------------------
   typedef struct {
      logic              imem;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t obs_q[$];            // writes seen on the DUT outputs

   int          m_pos;       // byte position inside the current frame
   int          m_cnt;
   int          m_addr;
   logic [31:0] m_word;
   logic [7:0]  m_csum;
   logic        m_imem;
   logic        m_done, m_err, m_ready;
   logic        m_exp_imem, m_exp_dmem;
   int          m_exp_addr;
   logic [31:0] m_exp_data;

   task automatic model_reset();
      m_pos = 0; m_cnt = 0; m_addr = 0; m_word = '0; m_csum = '0; m_imem = 1'b0;
      m_done = 1'b0; m_err = 1'b0; m_ready = 1'b0;
      m_exp_imem = 1'b0; m_exp_dmem = 1'b0; m_exp_addr = 0; m_exp_data = '0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (m_pos == 0) begin
         if (b == 8'hA5 || b == 8'h5A) begin
            m_imem = (b == 8'hA5); m_csum = 8'h00; m_pos = 1;
         end else if (b == 8'hFF) m_done = 1'b1;
         else                     m_err  = 1'b1;
      end else if (m_pos <= 4) begin
         case (m_pos)
            1: m_cnt  = int'(b) * 256;
            2: m_cnt  = m_cnt + int'(b);
            3: m_addr = int'(b) * 256;
            default: m_addr = (m_addr + int'(b)) % (1 << ADDR_W);
         endcase
         m_pos++;
         if (m_pos == 5 && m_cnt == 0 && !CSUM) m_pos = 0;
      end else if (m_pos < 5 + 4 * m_cnt) begin
         m_word = {m_word[23:0], b};
         m_csum = m_csum ^ b;
         if ((m_pos - 5) % 4 == 3) begin
            m_exp_imem = m_imem; m_exp_dmem = !m_imem;
            m_exp_addr = m_addr; m_exp_data = m_word;
            m_addr = (m_addr + 1) % (1 << ADDR_W);
         end
         m_pos++;
         if (m_pos == 5 + 4 * m_cnt && !CSUM) m_pos = 0;
      end else begin
         if (b == m_csum) m_pos = 0;
         else             m_err = 1'b1;
      end
   endtask

   // Compare process: outputs are checked at every falling edge, then the
   // model advances by the transfer the coming rising edge will perform.
   initial model_reset();

   always @(negedge clk) begin
      if (rst) begin
         check("rst_rx_ready",  rx_ready,  0);
         check("rst_imem_we",   imem_we,   0);
         check("rst_dmem_we",   dmem_we,   0);
         check("rst_mem_addr",  mem_addr,  0);
         check("rst_mem_wdata", mem_wdata, 0);
         check("rst_core_rstb", core_rstb, 0);
         check("rst_done",      done,      0);
         check("rst_err",       err,       0);
         model_reset();
      end else begin
         check("rx_ready",  rx_ready,  m_ready);
         check("done",      done,      m_done);
         check("core_rstb", core_rstb, m_done);
         check("err",       err,       m_err);
         check("imem_we",   imem_we,   m_exp_imem);
         check("dmem_we",   dmem_we,   m_exp_dmem);
         if (m_exp_imem || m_exp_dmem) begin
            check("mem_addr",  mem_addr,  m_exp_addr);
            check("mem_wdata", mem_wdata, m_exp_data);
         end
         if (imem_we || dmem_we) obs_q.push_back('{imem_we, mem_addr, mem_wdata});
         m_exp_imem = 1'b0;
         m_exp_dmem = 1'b0;
         if (rx_valid && rx_ready) model_byte(rx_data);
         m_ready = !(m_done || m_err);
      end
   end

   // ---------------- stimulus helpers --------------------------------------
   logic [7:0] fq[$];
   bit         g_gaps = 1'b0;

   task automatic frame_begin(input logic [7:0] hdr, input logic [15:0] cnt, input logic [15:0] addr);
      fq.delete();
      fq.push_back(hdr);
      fq.push_back(cnt[15:8]);  fq.push_back(cnt[7:0]);
      fq.push_back(addr[15:8]); fq.push_back(addr[7:0]);
   endtask

   task automatic add_word(input logic [31:0] w);
      fq.push_back(w[31:24]); fq.push_back(w[23:16]);
      fq.push_back(w[15:8]);  fq.push_back(w[7:0]);
   endtask

   task automatic add_csum();
      logic [7:0] x;
      x = 8'h00;
      for (int i = 5; i < fq.size(); i++) x = x ^ fq[i];
      if (CSUM) fq.push_back(x);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int gap;
      bit ok;
      ok  = 1'b0;
      gap = g_gaps ? int'($urandom_range(0, 2)) : 0;
      repeat (gap) begin
         rx_valid = 1'b0; rx_data = 8'($urandom);
         @(posedge clk); #1;
      end
      rx_valid = 1'b1; rx_data = b;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         if (rx_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      rx_valid = 1'b0;
      check("send_accepted", ok, 1);
   endtask

   task automatic send_q();
      for (int i = 0; i < fq.size(); i++) send_byte(fq[i]);
   endtask

   task automatic offer_byte(input logic [7:0] b, input int n);
      rx_valid = 1'b1; rx_data = b;
      repeat (n) @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      obs_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence -----------------------------------------
   int total_words;
   logic [31:0] w0, w1;

   initial begin
      idle(3);
      do_reset();

      // 1: two words into InstrMem from 0, then END. XOR of the data is 0x31.
      frame_begin(8'hA5, 16'd2, 16'h0000);
      add_word(32'hDEADBEEF); add_word(32'h00000013); add_csum();
`ifdef MIPS_LOADER_CSUM_EN
      check("t1_csum_byte", fq[13], 32'h31);
`endif
      send_q(); send_byte(8'hFF); idle(3);
      check("t1_nwrites", obs_q.size(), 2);
      if (obs_q.size() >= 2) begin
         check("t1_w0_imem", obs_q[0].imem, 1);
         check("t1_w0_addr", obs_q[0].addr, 32'h000);
         check("t1_w0_data", obs_q[0].data, 32'hDEADBEEF);
         check("t1_w1_addr", obs_q[1].addr, 32'h001);
         check("t1_w1_data", obs_q[1].data, 32'h00000013);
      end
      check("t1_done", done, 1);
      check("t1_core_rstb", core_rstb, 1);
      check("t1_rx_ready", rx_ready, 0);
      do_reset();

      // 2: one word into DataMem at 0x100
      frame_begin(8'h5A, 16'd1, 16'h0100);
      add_word(32'h12345678); add_csum();
      send_q(); send_byte(8'hFF); idle(3);
      check("t2_nwrites", obs_q.size(), 1);
      if (obs_q.size() >= 1) begin
         check("t2_imem", obs_q[0].imem, 0);
         check("t2_addr", obs_q[0].addr, 32'h100);
         check("t2_data", obs_q[0].data, 32'h12345678);
      end
      check("t2_done", done, 1);
      do_reset();

      // 3: address wrap 0x3FF -> 0x000
      w0 = $urandom; w1 = $urandom;
      frame_begin(8'hA5, 16'd2, 16'h03FF);
      add_word(w0); add_word(w1); add_csum();
      send_q(); idle(3);
      check("t3_nwrites", obs_q.size(), 2);
      if (obs_q.size() >= 2) begin
         check("t3_w0_addr", obs_q[0].addr, 32'h3FF);
         check("t3_w0_data", obs_q[0].data, w0);
         check("t3_w1_addr", obs_q[1].addr, 32'h000);
         check("t3_w1_data", obs_q[1].data, w1);
      end
      do_reset();

      // 4: trailing 0x00 is a wrong checksum (or an unknown header) -> ERROR
      frame_begin(8'hA5, 16'd2, 16'h0000);
      add_word(32'hDEADBEEF); add_word(32'h00000013);
      fq.push_back(8'h00);
      send_q(); idle(2);
      check("t4_err", err, 1);
      check("t4_rx_ready", rx_ready, 0);
      check("t4_core_rstb", core_rstb, 0);
      offer_byte(8'hFF, 4); idle(2);
      check("t4_ff_ignored_done", done, 0);
      check("t4_ff_ignored_rstb", core_rstb, 0);
      do_reset();

      // 5: zero-count frame, then an unknown header
      frame_begin(8'hA5, 16'd0, 16'h0010); add_csum();
      send_q(); idle(3);
      check("t5_no_writes", obs_q.size(), 0);
      check("t5_no_err", err, 0);
      check("t5_ready", rx_ready, 1);
      send_byte(8'h33); idle(2);
      check("t5_err", err, 1);
      check("t5_rx_ready", rx_ready, 0);
      do_reset();

      // 6: gaps, reset after the 2nd data byte, then a fresh load
      g_gaps = 1'b1;
      frame_begin(8'hA5, 16'd1, 16'h0020);
      add_word(32'hCAFEF00D);
      for (int i = 0; i < 7; i++) send_byte(fq[i]);
      rst = 1'b1;
      #1;
      check("t6_async_rstb", core_rstb, 0);
      check("t6_async_ready", rx_ready, 0);
      check("t6_async_imem", imem_we, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("t6_no_strobe", obs_q.size(), 0);
      obs_q.delete();
      frame_begin(8'h5A, 16'd1, 16'h0100);
      add_word(32'h12345678); add_csum();
      send_q(); send_byte(8'hFF); idle(3);
      check("t6_nwrites", obs_q.size(), 1);
      if (obs_q.size() >= 1) check("t6_data", obs_q[0].data, 32'h12345678);
      check("t6_done", done, 1);
      do_reset();

      // Random frames checked by the model
      total_words = 0;
      for (int f = 0; f < 25; f++) begin
         int cnt;
         g_gaps = 1'($urandom);
         cnt = int'($urandom_range(0, 3));
         frame_begin(($urandom % 2) ? 8'hA5 : 8'h5A, 16'(cnt), 16'($urandom));
         for (int k = 0; k < cnt; k++) add_word($urandom);
         add_csum();
         send_q();
         total_words += cnt;
      end
      send_byte(8'hFF); idle(3);
      check("rand_nwrites", obs_q.size(), total_words);
      check("rand_done", done, 1);
      check("rand_err", err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
